// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM encoding, the PC width and the default NOP word.
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc;
  } fetch_word_t;

  // Sequential fetch address; the add wraps naturally at 2^32.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word and its PC while the
// output slot is stalled. Clear beats push, push beats pop.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  fetch_word_t push_word,
  input  logic        pop,
  output logic        valid,
  output fetch_word_t word
);

  logic        valid_q, valid_d;
  fetch_word_t word_q, word_d;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      word_d  = push_word;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign valid = valid_q;
  assign word  = word_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding imem requester feeding a
// registered output slot backed by a one-entry skid buffer.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] instrn_out,
  output logic            instrn_valid,
  output logic [PC_W-1:0] pc_out
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            imem_req_q, imem_req_d;
  logic [PC_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic            valid_q, valid_d;

  logic        resp_fire;
  fetch_word_t resp_word;
  logic        skid_valid;
  fetch_word_t skid_word;
  logic        skid_push;
  logic        skid_pop;

  // A response is only usable in WAIT; a same-cycle redirect discards it.
  assign resp_fire = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign resp_word = '{instr: imem_rdata, pc: fetch_pc_q};
  assign skid_push = resp_fire && (stall || skid_valid);
  assign skid_pop  = !redirect_valid && !stall && skid_valid;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (skid_push),
    .push_word (resp_word),
    .pop       (skid_pop),
    .valid     (skid_valid),
    .word      (skid_word)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    out_pc_d   = out_pc_q;
    valid_d    = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!redirect_valid && !skid_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_gnt) begin
          fetch_pc_d = pc_q;
          pc_d       = next_pc(pc_q);
          state_d    = redirect_valid ? ST_DROP : ST_WAIT;
        end else if (redirect_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid)         state_d = ST_IDLE;
        else if (redirect_valid) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (skid_valid) begin
        instr_d  = skid_word.instr;
        out_pc_d = skid_word.pc;
        valid_d  = 1'b1;
      end else if (resp_fire) begin
        instr_d  = resp_word.instr;
        out_pc_d = resp_word.pc;
        valid_d  = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end

    imem_req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      imem_req_q <= 1'b0;
      instr_q    <= NOP_INSTR;
      out_pc_q   <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      imem_req_q <= imem_req_d;
      instr_q    <= instr_d;
      out_pc_q   <= out_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign instrn_out   = instr_q;
  assign instrn_valid = valid_q;
  assign pc_out       = out_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a responder/stimulus process models
// the memory and pushes expected words; a monitor pops on each transfer.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instrn_out;
  logic        instrn_valid;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instrn_out     (instrn_out),
    .instrn_valid   (instrn_valid),
    .pc_out         (pc_out)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  // Reference model: expected {instr, pc} in delivery order.
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr;
  logic [31:0] out_addr;
  logic [31:0] last_gnt_addr;
  bit          outstanding = 0;
  bit          live = 0;
  bit          wrap_seen = 0;
  int          delay = 0;

  int          p_gnt = 100, max_dly = 0, p_stall = 0, p_redir = 0;
  bit          force_wait_redir = 0;
  logic [31:0] force_target = '0;
  bit          mon_en = 0;

  task automatic drive_cycle();
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = $urandom;
    stall          = ($urandom_range(99) < p_stall);
    if (force_wait_redir && outstanding && delay >= 1) begin
      redirect_valid   = 1'b1;
      redirect_pc      = force_target;
      force_wait_redir = 0;
    end else if ($urandom_range(99) < p_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
    end
    if (outstanding) begin
      check("single_outstanding", {31'd0, imem_req}, 32'd0);
      if (delay == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(out_addr);
        outstanding = 0;
        if (live && !redirect_valid) exp_q.push_back({mem_word(out_addr), out_addr});
      end else begin
        delay--;
      end
    end else if (imem_req && $urandom_range(99) < p_gnt) begin
      check("imem_addr", imem_addr, exp_addr);
      if (imem_addr == 32'h0 && last_gnt_addr == 32'hFFFF_FFFC) wrap_seen = 1;
      last_gnt_addr = imem_addr;
      imem_gnt    = 1'b1;
      outstanding = 1;
      live        = 1;
      out_addr    = imem_addr;
      exp_addr    = exp_addr + 32'd4;
      delay       = $urandom_range(max_dly);
    end
    if (redirect_valid) begin
      live     = 0;
      exp_addr = redirect_pc;
      exp_q.delete();
    end
  endtask

  // Monitor: mid-cycle, inputs and outputs are stable for the next edge.
  logic [31:0] prev_instr, prev_pc;
  logic        prev_valid, prev_stall, prev_redir;
  bit          have_prev = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (!instrn_valid) check("nop_when_invalid", instrn_out, NOP);
        if (have_prev && prev_stall && !prev_redir) begin
          check("hold_instr", instrn_out, prev_instr);
          check("hold_pc", pc_out, prev_pc);
          check("hold_valid", {31'd0, instrn_valid}, {31'd0, prev_valid});
        end
        if (instrn_valid && !stall && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_instr: got pc=%h instr=%h, required no valid output", pc_out, instrn_out);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("instr", instrn_out, e[63:32]);
            check("pc_out", pc_out, e[31:0]);
            $display("[TB] out pc=%h instr=%h", pc_out, instrn_out);
          end
        end
        prev_instr = instrn_out;
        prev_pc    = pc_out;
        prev_valid = instrn_valid;
        prev_stall = stall;
        prev_redir = redirect_valid;
        have_prev  = 1;
      end else begin
        have_prev = 0;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_instr"}, instrn_out, NOP);
    check({tag, "_valid"}, {31'd0, instrn_valid}, 32'd0);
    check({tag, "_pc_out"}, pc_out, RST_PC);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, RST_PC);
  endtask

  initial begin
    int n;
    exp_addr      = RST_PC;
    last_gnt_addr = RST_PC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n  = 1'b1;
    mon_en = 1;

    // First fetch with immediate grant and response.
    p_gnt = 100; max_dly = 0; p_stall = 0; p_redir = 0;
    n = 0;
    do begin
      drive_cycle();
      n++;
    end while (!instrn_valid && n < 10);
    check("first_instr", instrn_out, 32'h00A0_0093);
    check("first_pc", pc_out, 32'h0);
    check("first_valid", {31'd0, instrn_valid}, 32'd1);
    repeat (12) drive_cycle();

    // Long stall: the skid fills and requests stop.
    p_stall = 100;
    repeat (8) drive_cycle();
    check("stall_no_req", {31'd0, imem_req}, 32'd0);
    p_stall = 0;
    repeat (8) drive_cycle();

    // Redirect while a response is pending.
    max_dly = 2; force_wait_redir = 1; force_target = 32'h0000_0100;
    n = 0;
    while (force_wait_redir && n < 40) begin
      drive_cycle();
      n++;
    end
    check("redir_taken", {31'd0, force_wait_redir}, 32'd0);
    drive_cycle();
    check("redir_clears_valid", {31'd0, instrn_valid}, 32'd0);
    repeat (16) drive_cycle();

    // Address wrap at the top of memory.
    max_dly = 1; force_wait_redir = 1; force_target = 32'hFFFF_FFFC;
    repeat (30) drive_cycle();
    check("wrap_seen", {31'd0, wrap_seen}, 32'd1);

    // Randomised traffic.
    p_gnt = 60; max_dly = 3; p_stall = 30; p_redir = 4;
    repeat (3000) drive_cycle();

    // Reset in the middle of an outstanding request, then a stray rvalid.
    p_gnt = 100; max_dly = 3; p_stall = 0; p_redir = 0;
    n = 0;
    do begin
      drive_cycle();
      n++;
    end while (!(outstanding && delay >= 1) && n < 50);
    check("mid_wait_reached", {31'd0, outstanding}, 32'd1);
    @(negedge clk);
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    check_reset_values("midreset");
    outstanding = 0;
    live        = 0;
    exp_q.delete();
    exp_addr = RST_PC;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    mon_en      = 1;
    p_gnt = 0;
    repeat (6) begin
      drive_cycle();
      check("stray_rvalid_ignored", {31'd0, instrn_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
